// File: rtl/lsu_mem_port.sv
// Load/store unit between the execute stage and the data memory bus.
// Accepts one load or store at a time, runs a req/gnt/rvalid bus
// transaction, and returns the sign- or zero-extended load result.
// Misaligned or illegal requests are rejected with a one-cycle err_o pulse
// and produce no bus activity.
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Unsupported encodings, stores of unsigned sizes and misaligned accesses.
  function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
    if (we && f3[2])                                  bad = 1'b1;
    if (f3[1:0] == 2'b01 && off[0])                   bad = 1'b1;
    if (f3[1:0] == 2'b10 && off != 2'b00)             bad = 1'b1;
    return bad;
  endfunction

  // Byte-lane enables for the access size at the given offset.
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store value across every lane it could land in.
  function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [2:0] f3,
                                                       input logic [DATA_WIDTH-1:0] wd);
    logic [DATA_WIDTH-1:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Shift the addressed lane down and sign- or zero-extend it.
  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [2:0] f3,
                                                     input logic [1:0] off,
                                                     input logic [DATA_WIDTH-1:0] word);
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] r;
    lane = word >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{lane[7]}}, lane[7:0]};
      3'b001:  r = {{16{lane[15]}}, lane[15:0]};
      3'b100:  r = {24'd0, lane[7:0]};
      3'b101:  r = {16'd0, lane[15:0]};
      default: r = lane;
    endcase
    return r;
  endfunction

  // Next-state, request capture and response generation.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (is_illegal(we_i, funct3_i, addr_i[1:0])) begin
            err_d = 1'b1;
          end else begin
            we_d     = we_i;
            funct3_d = funct3_i;
            off_d    = addr_i[1:0];
            addr_d   = {addr_i[ADDR_WIDTH-1:2], 2'b00};
            be_d     = lane_be(funct3_i, addr_i[1:0]);
            wdata_d  = lane_wdata(funct3_i, wdata_i);
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          if (we_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (mem_rvalid_i) begin
          rdata_d = load_ext(funct3_q, off_q, mem_rdata_i);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured request and registered responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = (state_q == REQ) & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit sitting between the execute datapath and the data memory bus.
- Takes the ALU-computed address, the rs2 store value and funct3 from the core, and runs a req/gnt/rvalid transaction on the memory bus.
- Returns the sign- or zero-extended load value that feeds the register-file write-back mux.
- Holds the core busy while a transaction is outstanding.

Parameters:
- ADDR_WIDTH, 32, byte address width on both core and bus sides.
- DATA_WIDTH, 32, data width; only 32 is supported (4 byte lanes).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  1  core requests a load/store this cycle
- we_i  input  1  [1] store, [0] load
- funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  input  ADDR_WIDTH  byte address (ALU output)
- wdata_i  input  DATA_WIDTH  store data (rs2 value)
- busy_o  output  1  transaction in progress; core must stall
- done_o  output  1  one-cycle pulse: transaction complete
- err_o  output  1  one-cycle pulse: misaligned or illegal request rejected
- rdata_o  output  DATA_WIDTH  extended load result
- mem_req_o  output  1  bus request
- mem_we_o  output  1  bus write
- mem_addr_o  output  ADDR_WIDTH  word-aligned address (addr[1:0] forced to 00)
- mem_be_o  output  4  byte enables
- mem_wdata_o  output  DATA_WIDTH  lane-replicated store data
- mem_gnt_i  input  1  bus accepted request this cycle
- mem_rvalid_i  input  1  load data valid
- mem_rdata_i  input  DATA_WIDTH  load data word

Behaviour:
- All outputs are registered or decoded from state. Reset value of every output is 0.
- FSM states: IDLE, REQ, WAIT_R. busy_o = (state != IDLE).
- IDLE, on req_valid_i:
  - Legal request: capture we, funct3, addr[1:0], aligned addr, mem_be, mem_wdata; go to REQ.
  - Illegal request:
    - funct3 in {011, 110, 111}.
    - Store with funct3 100 or 101.
    - H/HU with addr[0]=1.
    - W with addr[1:0]!=00.
    - Response: err_o = 1 next cycle, stay in IDLE, no bus activity, no done_o.
- REQ:
  - mem_req_o = 1; address, we, be and wdata are held stable until grant.
  - On mem_gnt_i: a store goes to IDLE with done_o = 1 the next cycle; a load goes to WAIT_R.
- WAIT_R: mem_req_o = 0. On mem_rvalid_i: latch the extended value into rdata_o, pulse done_o next cycle, go to IDLE.
- rvalid is accepted only in WAIT_R; rvalid or gnt in any other state is ignored.
- Byte enables and store data:
  - B: be = 0001 << addr[1:0]; wdata = wdata[7:0] replicated x4.
  - H: be = 0011 (addr[1]=0) or 1100 (addr[1]=1); wdata = wdata[15:0] replicated x2.
  - W: be = 1111; wdata unchanged.
  - Loads drive the same be pattern, with mem_we_o = 0.
- Load extraction:
  - lane = mem_rdata_i >> (8 * addr[1:0]).
  - B/H: sign-extend bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
- rdata_o holds its value until the next load completes. Stores and errors do not change it.
- req_valid_i while busy_o = 1 is ignored (no queueing).
- A new request is accepted in the same cycle done_o is high, because state is already IDLE.
- Minimum latency, counted from the acceptance cycle t:
  - mem_req_o at t+1.
  - Store with immediate gnt: done_o at t+2.
  - Load with gnt at t+1 and rvalid at t+2: done_o at t+3.
- Reset mid-operation: returns to IDLE asynchronously and drops mem_req_o immediately. A late rvalid from the aborted load is ignored, and rdata_o = 0.

Test Plan:
- SW addr 0x104, wdata 0xDEADBEEF, gnt held low 3 cycles:
  - mem_req_o high 3 cycles with addr 0x104, be 1111 stable.
  - done_o 1 cycle after gnt; busy_o high throughout.
- SB addr 0x203, wdata 0x000000A5:
  - mem_addr_o 0x200, be 1000, mem_wdata_o 0xA5A5A5A5.
  - SH addr 0x202: be 1100.
- LB addr 0x11, rdata word 0x12F08034:
  - rdata_o 0xFFFFFF80.
  - LBU gives 0x00000080; LH addr 0x12 gives 0x000012F0.
  - LHU addr 0x10 gives 0x00008034; LW addr 0x10 gives 0x12F08034.
- LW addr 0x6 or LH addr 0x5, or funct3 011:
  - err_o pulse only; mem_req_o stays 0, no done_o, busy_o 0, rdata_o unchanged.
- Load granted, then rst_ni low before rvalid:
  - mem_req_o/busy_o drop immediately; a later rvalid is ignored; rdata_o = 0.
- Back-to-back: new req_valid_i in the done_o cycle is accepted; second mem_req_o follows 1 cycle later.
- req_valid_i pulses while busy are dropped.
